// File: rtl/icmem_fetch.sv
// -----------------------------------------------------------------------------
// icmem_fetch
//
// Instruction store with a built-in fetch sequencer, sitting between the
// boot/test loader and the core decode stage.
//
// A load phase writes a program of variable length into the store, starting at
// slot 0. A run phase then fetches the program sequentially. Fetch supports:
//   - stall
//   - branch redirect
//   - halt once the PC leaves the loaded program
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   load_valid  write load_data into the next load slot
//   load_data   instruction word to store
//   load_last   qualifies load_valid; marks the final program word
//   start       begin fetching from PC 0 (IDLE with a program, or HALT)
//   stall       freeze fetch; pc and the fetch outputs hold
//   br_taken    redirect fetch to br_target (wins over stall)
//   br_target   branch destination
//   inst        fetched instruction (registered memory read)
//   inst_pc     address of inst
//   inst_valid  inst/inst_pc carry a valid fetch this cycle
//   load_full   every slot has been written; loads from IDLE are ignored
//   prog_len    number of words in the loaded program
//   state       0 IDLE, 1 LOAD, 2 RUN, 3 HALT
// -----------------------------------------------------------------------------
module icmem_fetch #(
  parameter  int ISA_WIDTH = 16,
  parameter  int PC_WIDTH  = 16,
  parameter  int DEPTH     = 32,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  input  logic [ISA_WIDTH-1:0] load_data,
  input  logic                 load_last,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [PC_WIDTH-1:0]  br_target,
  output logic [ISA_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]  inst_pc,
  output logic                 inst_valid,
  output logic                 load_full,
  output logic [ADDR_W:0]      prog_len,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Storage. No reset, so the array maps onto block RAM. The read side is
  // registered into inst_q below.
  // ---------------------------------------------------------------------------
  logic [ISA_WIDTH-1:0] mem [DEPTH];

  state_t               state_q,      state_d;
  logic [PC_WIDTH-1:0]  pc_q,         pc_d;
  logic [ADDR_W-1:0]    wptr_q,       wptr_d;
  logic [ADDR_W:0]      prog_len_q,   prog_len_d;
  logic [ISA_WIDTH-1:0] inst_q;
  logic [PC_WIDTH-1:0]  inst_pc_q,    inst_pc_d;
  logic                 inst_valid_q, inst_valid_d;
  logic                 load_full_q,  load_full_d;

  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic                 fetch_en;
  logic                 begin_load;
  logic                 pc_in_prog;
  logic [ADDR_W-1:0]    pc_idx;

  // prog_len never exceeds DEPTH < 2**PC_WIDTH, so zero-extending it to the
  // PC width makes the comparison exact.
  assign pc_in_prog = (pc_q < PC_WIDTH'(prog_len_q));

  // Only meaningful once pc_in_prog holds. The upper PC bits are covered by
  // that check.
  assign pc_idx = pc_q[ADDR_W-1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    wptr_d       = wptr_q;
    prog_len_d   = prog_len_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    load_full_d  = load_full_q;
    mem_we       = 1'b0;
    mem_waddr    = wptr_q;
    fetch_en     = 1'b0;
    begin_load   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A full store refuses further loads from IDLE. Reloading a full
        // store goes through HALT (run the program, then load).
        if (load_valid && !load_full_q) begin
          begin_load = 1'b1;
        end else if (start && (prog_len_q != '0)) begin
          pc_d    = '0;
          state_d = S_RUN;
        end
      end

      S_LOAD: begin
        if (load_valid) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          // Filling the last slot closes the program, just like load_last.
          if (load_last || (wptr_q == LAST_SLOT)) begin
            prog_len_d  = {1'b0, wptr_q} + (ADDR_W+1)'(1);
            load_full_d = (wptr_q == LAST_SLOT);
            state_d     = S_IDLE;
          end
        end
      end

      S_RUN: begin
        if (br_taken) begin
          // The redirect takes effect even under stall. The old fetch is
          // dropped, and the target is range-checked on the next cycle.
          pc_d         = br_target;
          inst_valid_d = 1'b0;
        end else if (stall) begin
          // Hold everything.
        end else if (!pc_in_prog) begin
          inst_valid_d = 1'b0;
          state_d      = S_HALT;
        end else begin
          fetch_en     = 1'b1;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + 1'b1;
        end
      end

      S_HALT: begin
        if (load_valid) begin
          begin_load = 1'b1;
        end else if (start) begin
          pc_d    = '0;
          state_d = S_RUN;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Start of a fresh program. Slot 0 is written now, and the old length and
    // full flag are discarded. A one-word program closes immediately.
    if (begin_load) begin
      mem_we       = 1'b1;
      mem_waddr    = '0;
      wptr_d       = ADDR_W'(1);
      load_full_d  = 1'b0;
      inst_valid_d = 1'b0;
      if (load_last) begin
        prog_len_d = (ADDR_W+1)'(1);
        state_d    = S_IDLE;
      end else begin
        prog_len_d = '0;
        state_d    = S_LOAD;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= load_data;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      wptr_q       <= '0;
      prog_len_q   <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      load_full_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wptr_q       <= wptr_d;
      prog_len_q   <= prog_len_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      load_full_q  <= load_full_d;
      // Registered read. inst changes only on an actual fetch, so it holds
      // through stall, branch and halt.
      if (fetch_en) begin
        inst_q <= mem[pc_idx];
      end
    end
  end

  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign load_full  = load_full_q;
  assign prog_len   = prog_len_q;
  assign state      = state_q;

endmodule

// File: tb/tb_icmem_fetch.sv
// -----------------------------------------------------------------------------
// tb_icmem_fetch
//
// Directed bench for icmem_fetch (default parameters).
//
// The stimulus pushes the expected {inst_pc, inst} for every valid fetch into
// a queue. An independent monitor pops and compares on each cycle where
// inst_valid is high. Control and status outputs are checked directly by the
// stimulus process at hand-computed cycles.
// -----------------------------------------------------------------------------
module tb_icmem_fetch;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        start;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        load_full;
  logic [5:0]  prog_len;
  logic [1:0]  state;

  icmem_fetch #(.ISA_WIDTH(16), .PC_WIDTH(16), .DEPTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .start      (start),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .load_full  (load_full),
    .prog_len   (prog_len),
    .state      (state)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) begin
      passes++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int pc, input logic [15:0] word);
    exp_t e;
    e.pc   = 16'(pc);
    e.word = word;
    exp_q.push_back(e);
  endtask

  // Monitor: one comparison pair per presented fetch.
  always @(negedge clk) begin
    exp_t e;
    if (rst && inst_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_fetch: got pc=%0d inst=0x%h, expected no valid fetch", inst_pc, inst);
      end else begin
        e = exp_q.pop_front();
        chk("fetch_pc", 32'(inst_pc), 32'(e.pc));
        chk("fetch_inst", 32'(inst), 32'(e.word));
        $display("fetch pc=%0d inst=0x%h (expected pc=%0d inst=0x%h)", inst_pc, inst, e.pc, e.word);
      end
    end
  end

  // Safety net in case the stimulus never completes.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  logic [15:0] prog4 [4];

  initial begin
    prog4[0] = 16'h1111;
    prog4[1] = 16'h2222;
    prog4[2] = 16'h3333;
    prog4[3] = 16'h4444;

    load_valid = 0; load_data = 0; load_last = 0; start = 0;
    stall = 0; br_taken = 0; br_target = 0;

    // ---- Reset ---------------------------------------------------------
    rst = 1;
    #1 rst = 0;
    #2;
    chk("rst_inst", 32'(inst), 32'h0);
    chk("rst_inst_pc", 32'(inst_pc), 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_prog_len", 32'(prog_len), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_load_full", 32'(load_full), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    tick();
    start = 1;
    tick();
    start = 0;
    chk("start_no_prog_state", 32'(state), 32'h0);

    // ---- Load 4 words, run to halt ---------------------------------------
    for (int i = 0; i < 4; i++) begin
      load_valid = 1; load_data = prog4[i]; load_last = (i == 3);
      tick();
      if (i == 0) chk("load_state", 32'(state), 32'h1);
    end
    load_valid = 0; load_last = 0;
    chk("load4_prog_len", 32'(prog_len), 32'd4);
    chk("load4_state", 32'(state), 32'h0);
    chk("load4_full", 32'(load_full), 32'h0);
    $display("loaded 4-word program, prog_len=%0d", prog_len);

    for (int i = 0; i < 4; i++) push(i, prog4[i]);
    start = 1;
    tick();                                // edge N
    start = 0;
    chk("run_state", 32'(state), 32'h2);
    for (int i = 0; i < 4; i++) tick();    // edges N+1..N+4
    tick();                                // edge N+5
    chk("halt_valid", 32'(inst_valid), 32'h0);
    chk("halt_state", 32'(state), 32'h3);
    chk("halt_inst_hold", 32'(inst), 32'h4444);
    chk("halt_pc_hold", 32'(inst_pc), 32'd3);
    chk("run1_drained", 32'(exp_q.size()), 32'd0);

    // ---- Stall for 3 cycles while inst_pc=1 -----------------------------
    // inst_pc=1 is shown once by its own fetch, then held through 3 stalls.
    push(0, 16'h1111);
    for (int i = 0; i < 4; i++) push(1, 16'h2222);
    push(2, 16'h3333);
    push(3, 16'h4444);
    start = 1;
    tick();                                // N
    start = 0;
    tick();                                // N+1: pc 0
    tick();                                // N+2: pc 1
    stall = 1;
    for (int i = 0; i < 3; i++) tick();    // N+3..N+5 held
    stall = 0;
    tick();                                // N+6: pc 2
    tick();                                // N+7: pc 3
    tick();                                // N+8: halt
    chk("stall_halt_state", 32'(state), 32'h3);
    chk("stall_drained", 32'(exp_q.size()), 32'd0);
    $display("stall run complete");

    // ---- Branch back to 0, then out of range under stall ----------------
    push(0, 16'h1111);
    push(1, 16'h2222);
    push(2, 16'h3333);
    push(0, 16'h1111);
    push(1, 16'h2222);
    start = 1;
    tick();                                // N
    start = 0;
    tick(); tick(); tick();                // N+1..N+3: pc 0,1,2
    br_taken = 1; br_target = 16'd0;
    tick();                                // N+4: redirect
    br_taken = 0;
    chk("br0_valid", 32'(inst_valid), 32'h0);
    chk("br0_state", 32'(state), 32'h2);
    tick(); tick();                        // N+5, N+6: pc 0,1
    br_taken = 1; br_target = 16'd9; stall = 1;
    tick();                                // N+7: redirect despite stall
    br_taken = 0; stall = 0;
    chk("br9_valid", 32'(inst_valid), 32'h0);
    tick();                                // N+8: out of range -> halt
    chk("br9_halt_state", 32'(state), 32'h3);
    chk("br9_halt_valid", 32'(inst_valid), 32'h0);
    tick();
    chk("br_drained", 32'(exp_q.size()), 32'd0);
    $display("branch run complete");

    // ---- Fill all 32 slots from HALT -------------------------------------
    for (int i = 0; i < 32; i++) begin
      load_valid = 1; load_data = 16'hA000 + 16'(i); load_last = 0;
      tick();
      if (i == 0) begin
        chk("reload_prog_len_cleared", 32'(prog_len), 32'h0);
        chk("reload_state", 32'(state), 32'h1);
      end
    end
    chk("full_flag", 32'(load_full), 32'h1);
    chk("full_prog_len", 32'(prog_len), 32'd32);
    chk("full_state", 32'(state), 32'h0);
    load_data = 16'hFFFF;                  // 33rd word must be ignored
    tick();
    load_valid = 0;
    chk("full_ignore_prog_len", 32'(prog_len), 32'd32);
    chk("full_ignore_flag", 32'(load_full), 32'h1);
    chk("full_ignore_state", 32'(state), 32'h0);
    $display("loaded 32-word program, load_full=%0d", load_full);

    for (int i = 0; i < 32; i++) push(i, 16'hA000 + 16'(i));
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 32; i++) tick();
    tick();
    chk("full_run_halt", 32'(state), 32'h3);
    chk("full_run_drained", 32'(exp_q.size()), 32'd0);

    // ---- Reset in the middle of a run -------------------------------------
    push(0, 16'hA000);
    push(1, 16'hA001);
    push(2, 16'hA002);
    start = 1;
    tick();
    start = 0;
    tick(); tick(); tick();                // inst_pc=2 now presented
    @(negedge clk);                        // let the monitor take pc 2
    #1 rst = 0;
    #1;
    chk("midrst_inst", 32'(inst), 32'h0);
    chk("midrst_inst_pc", 32'(inst_pc), 32'h0);
    chk("midrst_valid", 32'(inst_valid), 32'h0);
    chk("midrst_prog_len", 32'(prog_len), 32'h0);
    chk("midrst_state", 32'(state), 32'h0);
    chk("midrst_full", 32'(load_full), 32'h0);
    #1 rst = 1;
    start = 1;
    tick();
    start = 0;
    tick();
    chk("post_rst_start_state", 32'(state), 32'h0);
    chk("post_rst_valid", 32'(inst_valid), 32'h0);
    chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
